// File: rtl/ack_bus_pkg.sv
// Shared definitions for the acknowledge-bus requester: bus source IDs, idle ID, FSM encoding.
package ack_bus_pkg;

    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 3;

    localparam logic [ID_W-1:0] SRC_MEM     = 2'b00;
    localparam logic [ID_W-1:0] SRC_SHA     = 2'b01;
    localparam logic [ID_W-1:0] SRC_AES     = 2'b10;
    localparam logic [ID_W-1:0] SRC_CTRL    = 2'b11;
    localparam logic [ID_W-1:0] ACK_ID_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b10
    } req_state_e;

endpackage

// File: rtl/ack_timeout_ctr.sv
// Counts consecutive REQ cycles; flags expiry on the last allowed cycle so the owner can abandon the ack.
module ack_timeout_ctr
    import ack_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Held at zero outside REQ, so every REQ entry starts a fresh count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (!expired_c) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired_c = active && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ack_bus_requester.sv
// Queues completed-transaction acks and requests the shared ack bus, one ack per grant.
// Optional REQ-state timeout is enabled by defining ACK_REQ_TIMEOUT_EN.
module ack_bus_requester
    import ack_bus_pkg::*;
#(
    parameter logic [1:0]  SOURCE_ID      = SRC_MEM,
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ack_in_valid,
    output logic             ack_in_ready,
    output logic             req,
    output logic             ack_valid_n_o,
    output logic [ID_W-1:0]  ack_id_o,
    input  logic             ack_ready,
    input  logic [ID_W-1:0]  winner_source_id,
    output logic             ack_done,
    output logic [CNT_W-1:0] pending_count,
    output logic             timeout_err
);

    if (DEPTH < 1 || DEPTH > 7 || TIMEOUT_CYCLES == 0) begin : g_param_chk
        $error("ack_bus_requester: DEPTH must be 1..7 and TIMEOUT_CYCLES nonzero");
    end

    req_state_e       state;
    req_state_e       state_next;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             grant;
    logic             expire;
    logic             pop;

    assign push  = ack_in_valid && ack_in_ready;
    assign grant = (state == ST_REQ) && ack_ready && (winner_source_id == SOURCE_ID);
    assign pop   = grant || expire;

`ifdef ACK_REQ_TIMEOUT_EN
    logic tmo_c;

    ack_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .active    (state == ST_REQ),
        .expired_c (tmo_c)
    );

    // A grant on the expiry cycle wins; the ack is delivered, not abandoned
    assign expire = tmo_c && !grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= expire;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Pending count: push and pop on the same edge cancel
    always_comb begin
        count_next = pending_count;
        if (push && !pop) begin
            count_next = pending_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = pending_count - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (pending_count != '0) state_next = ST_REQ;
            ST_REQ:  if (pop) state_next = ST_GAP;
            ST_GAP:  state_next = (pending_count != '0) ? ST_REQ : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State plus registered bus outputs decoded from the upcoming state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            pending_count <= '0;
            ack_in_ready  <= 1'b1;
            req           <= 1'b0;
            ack_valid_n_o <= 1'b1;
            ack_id_o      <= ACK_ID_IDLE;
            ack_done      <= 1'b0;
        end else begin
            state         <= state_next;
            pending_count <= count_next;
            ack_in_ready  <= (count_next < CNT_W'(DEPTH));
            ack_done      <= grant;
            req           <= (state_next == ST_REQ);
            ack_valid_n_o <= (state_next != ST_REQ);
            ack_id_o      <= (state_next == ST_REQ) ? SOURCE_ID : ACK_ID_IDLE;
        end
    end

endmodule
